// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between the instruction-fetch
// (read-only) port and the data load/store port. Round-robin on contention,
// one transaction at a time, acknowledge on the matching done edge, a
// watchdog that aborts a transaction whose done never arrives, and an
// enforced idle gap on sram_enable between transactions.
module sram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned GAP_CYCLES     = 10
) (
  input  logic        clk,
  input  logic        rst,
  // instruction port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  // SRAM controller side
  output logic        sram_enable,
  output logic        sram_writenable,
  output logic [31:0] sram_address,
  output logic [31:0] sram_data_write,
  input  logic [31:0] sram_data_read,
  input  logic        sram_read_done,
  input  logic        sram_write_done,
  // status
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [1:0]  r_grant;
  logic        r_last_d;     // 1: the most recent grant went to the data port
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_i_rdata;
  logic [31:0] r_d_rdata;
  logic        r_i_ack;
  logic        r_d_ack;
  logic        r_i_err;
  logic        r_d_err;
  logic        r_rd_q;
  logic        r_wr_q;
  logic [31:0] r_wdog;
  logic [31:0] r_gap;

  logic        w_edge_rd;
  logic        w_edge_wr;
  logic        w_hit;
  logic        w_timeout;
  logic        w_exit;
  logic        w_pick_i;
  logic        w_pick_d;
  logic        w_gap_done;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_pick_i || w_pick_d) w_state_nxt = BUSY;
      BUSY:    if (w_exit)               w_state_nxt = RELEASE;
      RELEASE: if (w_gap_done)           w_state_nxt = IDLE;
      default:                           w_state_nxt = IDLE;
    endcase
  end

  // Control decisions: arbitration pick, done-edge match, watchdog, gap end.
  // The done registers track the inputs every cycle, so a level that is
  // already high when BUSY is entered never looks like an edge.
  // RELEASE leaves on the cycle the gap counter steps from 1 to 0, which
  // makes the next grant land exactly GAP_CYCLES+1 cycles after the ack.
  always_comb begin
    w_edge_rd  = sram_read_done  & ~r_rd_q;
    w_edge_wr  = sram_write_done & ~r_wr_q;
    w_hit      = (r_state == BUSY) && (r_we ? w_edge_wr : w_edge_rd);
    w_timeout  = (r_state == BUSY) && !w_hit && (r_wdog == TIMEOUT_CYCLES);
    w_exit     = w_hit || w_timeout;
    w_pick_i   = (r_state == IDLE) && i_req && (!d_req || r_last_d);
    w_pick_d   = (r_state == IDLE) && d_req && (!i_req || !r_last_d);
    w_gap_done = (r_gap <= 32'd1) && !sram_read_done && !sram_write_done;
  end

  // Datapath: transaction registers, acks, read data, watchdog and gap counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant   <= '0;
      r_last_d  <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_d_err   <= 1'b0;
      r_rd_q    <= 1'b0;
      r_wr_q    <= 1'b0;
      r_wdog    <= '0;
      r_gap     <= '0;
    end else begin
      r_rd_q  <= sram_read_done;
      r_wr_q  <= sram_write_done;
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      r_i_err <= 1'b0;
      r_d_err <= 1'b0;

      if (w_pick_i) begin
        r_grant <= 2'b01;
        r_we    <= 1'b0;
        r_addr  <= i_addr;
        r_wdog  <= '0;
      end else if (w_pick_d) begin
        r_grant <= 2'b10;
        r_we    <= d_we;
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        r_wdog  <= '0;
      end

      if (r_state == BUSY) begin
        if (w_exit) begin
          r_grant  <= '0;
          r_we     <= 1'b0;
          r_last_d <= r_grant[1];
          r_gap    <= GAP_CYCLES;
          if (r_grant[0]) begin
            r_i_ack <= 1'b1;
            r_i_err <= w_timeout;
            if (w_hit && !r_we) r_i_rdata <= sram_data_read;
          end
          if (r_grant[1]) begin
            r_d_ack <= 1'b1;
            r_d_err <= w_timeout;
            if (w_hit && !r_we) r_d_rdata <= sram_data_read;
          end
        end else begin
          r_wdog <= r_wdog + 32'd1;
        end
      end

      if ((r_state == RELEASE) && (r_gap != '0)) begin
        r_gap <= r_gap - 32'd1;
      end
    end
  end

  assign sram_enable     = (r_state == BUSY);
  assign sram_writenable = r_we;
  assign sram_address    = r_addr;
  assign sram_data_write = r_wdata;
  assign grant           = r_grant;
  assign busy            = (r_state != IDLE);
  assign i_rdata         = r_i_rdata;
  assign d_rdata         = r_d_rdata;
  assign i_ack           = r_i_ack;
  assign d_ack           = r_d_ack;
  assign i_err           = r_i_err;
  assign d_err           = r_d_err;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter with a behavioural SRAM
// controller and a scoreboard that checks every acknowledge in order.
module tb_sram_arbiter;

  localparam int unsigned TO  = 255;
  localparam int unsigned GAP = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        d_err;
  logic        sram_enable;
  logic        sram_writenable;
  logic [31:0] sram_address;
  logic [31:0] sram_data_write;
  logic [31:0] sram_data_read;
  logic        sram_read_done;
  logic        sram_write_done;
  logic [1:0]  grant;
  logic        busy;

  sram_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .GAP_CYCLES    (GAP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req           (i_req),
    .i_addr          (i_addr),
    .i_rdata         (i_rdata),
    .i_ack           (i_ack),
    .i_err           (i_err),
    .d_req           (d_req),
    .d_we            (d_we),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_rdata         (d_rdata),
    .d_ack           (d_ack),
    .d_err           (d_err),
    .sram_enable     (sram_enable),
    .sram_writenable (sram_writenable),
    .sram_address    (sram_address),
    .sram_data_write (sram_data_write),
    .sram_data_read  (sram_data_read),
    .sram_read_done  (sram_read_done),
    .sram_write_done (sram_write_done),
    .grant           (grant),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Expected acknowledge: port (0 = instruction, 1 = data), err, rdata of that port
  typedef struct packed {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_vec = 0;
  int          n_err = 0;
  int          cy;
  int          low;
  int          model_mode;   // 0 normal, 1 wrong done only, 2 silent
  logic [31:0] model_rdata;
  logic        m_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.port  = port;
    e.err   = err;
    e.rdata = rdata;
    q.push_back(e);
  endtask

  task automatic wait_ack(input string name, output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      cycles++;
      if (i_ack || d_ack) break;
      if (cycles >= 600) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: no ack after %0d cycles, expected one", name, cycles);
        break;
      end
    end
  endtask

  task automatic wait_enable(input string name, output int lowcnt);
    lowcnt = 0;
    forever begin
      @(negedge clk);
      if (sram_enable) break;
      lowcnt++;
      if (lowcnt >= 600) begin
        n_vec++;
        n_err++;
        $display("FAIL %s: no grant after %0d cycles, expected one", name, lowcnt);
        break;
      end
    end
  endtask

  // Behavioural SRAM controller: answers two cycles after seeing enable,
  // holds the done level for four cycles, then waits for enable to drop.
  initial begin
    sram_read_done  = 1'b0;
    sram_write_done = 1'b0;
    sram_data_read  = '0;
    forever begin
      @(posedge clk); #1;
      if (sram_enable) begin
        m_we = sram_writenable;
        repeat (2) @(posedge clk);
        #1;
        sram_data_read = model_rdata;
        if (model_mode == 0) begin
          if (m_we) sram_write_done = 1'b1;
          else      sram_read_done  = 1'b1;
        end else if (model_mode == 1) begin
          sram_write_done = 1'b1;
        end
        repeat (4) @(posedge clk);
        #1;
        sram_read_done  = 1'b0;
        sram_write_done = 1'b0;
        while (sram_enable) begin
          @(posedge clk); #1;
        end
      end
    end
  end

  // Scoreboard monitor: every ack must match the oldest expectation
  always @(negedge clk) begin
    if (i_ack || d_ack) begin
      chk("ack_enable_low", 32'(sram_enable), 32'd0);
      chk("ack_grant_clear", 32'(grant), 32'd0);
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: i_ack=%b d_ack=%b, expected none", i_ack, d_ack);
      end else begin
        mon_e = q.pop_front();
        chk("ack_port", 32'({d_ack, i_ack}), mon_e.port ? 32'd2 : 32'd1);
        chk("ack_err", 32'({d_err, i_err}), mon_e.err ? (mon_e.port ? 32'd2 : 32'd1) : 32'd0);
        chk("ack_rdata", mon_e.port ? d_rdata : i_rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "bench timeout");
  end

  initial begin
    i_req       = 1'b0;
    i_addr      = '0;
    d_req       = 1'b0;
    d_we        = 1'b0;
    d_addr      = '0;
    d_wdata     = '0;
    model_mode  = 0;
    model_rdata = '0;
    rst         = 1'b1;
    #3 rst      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_enable", 32'({sram_enable, sram_writenable}), 32'd0);
    chk("rst_address", sram_address, 32'd0);
    chk("rst_data_write", sram_data_write, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_ack_err", 32'({i_ack, d_ack, i_err, d_err}), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    // Single instruction read: grant one cycle after the sampled request
    model_mode  = 0;
    model_rdata = 32'hDEADBEEF;
    push_exp(1'b0, 1'b0, 32'hDEADBEEF);
    i_addr = 32'h100;
    i_req  = 1'b1;
    @(negedge clk);
    chk("rd_enable", 32'(sram_enable), 32'd1);
    chk("rd_grant", 32'(grant), 32'd1);
    chk("rd_busy", 32'(busy), 32'd1);
    chk("rd_address", sram_address, 32'h100);
    chk("rd_writenable", 32'(sram_writenable), 32'd0);
    wait_ack("rd_ack", cy);
    i_req = 1'b0;

    // Data read to give d_rdata a known value
    model_rdata = 32'hCAFEF00D;
    push_exp(1'b1, 1'b0, 32'hCAFEF00D);
    d_addr = 32'h80;
    d_we   = 1'b0;
    d_req  = 1'b1;
    wait_enable("drd_grant_wait", low);
    chk("drd_grant", 32'(grant), 32'd2);
    chk("drd_gap", 32'(low), 32'(GAP));
    wait_ack("drd_ack", cy);
    d_req = 1'b0;

    // Data write: d_rdata must keep the previous read value
    model_rdata = 32'h55AA55AA;
    push_exp(1'b1, 1'b0, 32'hCAFEF00D);
    d_addr  = 32'h40;
    d_wdata = 32'h12345678;
    d_we    = 1'b1;
    d_req   = 1'b1;
    wait_enable("wr_grant_wait", low);
    chk("wr_grant", 32'(grant), 32'd2);
    chk("wr_writenable", 32'(sram_writenable), 32'd1);
    chk("wr_address", sram_address, 32'h40);
    chk("wr_data_write", sram_data_write, 32'h12345678);
    wait_ack("wr_ack", cy);
    d_req = 1'b0;
    d_we  = 1'b0;

    // Contention: last grant was data, so I, D, I, D
    model_rdata = 32'h0BADF00D;
    i_addr = 32'h200;
    d_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      push_exp(k[0], 1'b0, 32'h0BADF00D);
    end
    i_req = 1'b1;
    d_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_enable("rr_grant_wait", low);
      chk("rr_grant", 32'(grant), k[0] ? 32'd2 : 32'd1);
      chk("rr_address", sram_address, k[0] ? 32'h300 : 32'h200);
      // low counts the cycles after the ack cycle itself
      chk("rr_gap", 32'(low), 32'(GAP));
      wait_ack("rr_ack", cy);
      if (k == 3) begin
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end

    // Wrong done then silence: watchdog abort, i_rdata unchanged
    model_mode  = 1;
    model_rdata = 32'hFFFF0000;
    push_exp(1'b0, 1'b1, 32'h0BADF00D);
    i_addr = 32'h500;
    i_req  = 1'b1;
    wait_enable("to_grant_wait", low);
    chk("to_grant", 32'(grant), 32'd1);
    wait_ack("to_ack", cy);
    chk("to_latency", 32'(cy), 32'(TO + 1));
    i_req = 1'b0;

    // Recovery after the abort
    model_mode  = 0;
    model_rdata = 32'h600D600D;
    push_exp(1'b0, 1'b0, 32'h600D600D);
    i_addr = 32'h600;
    i_req  = 1'b1;
    wait_enable("rec_grant_wait", low);
    chk("rec_address", sram_address, 32'h600);
    wait_ack("rec_ack", cy);
    i_req = 1'b0;

    // Reset in the middle of BUSY: outputs clear without a clock edge
    model_mode = 2;
    d_addr = 32'h700;
    d_req  = 1'b1;
    wait_enable("mr_grant_wait", low);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mr_enable", 32'(sram_enable), 32'd0);
    chk("mr_grant", 32'(grant), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_i_rdata", i_rdata, 32'd0);
    chk("mr_address", sram_address, 32'd0);
    chk("mr_data_write", sram_data_write, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_enable", 32'(sram_enable), 32'd0);
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares the single off-chip SRAM controller between the CPU's instruction-fetch port and its data (load/store) port. Accepts independent level requests from both, grants one at a time with round-robin on contention, drives the controller's `enable`/`writenable`/`address`/`data_write` inputs, and returns data plus a one-cycle acknowledge when the controller's done pulse arrives. It sits between the pipeline's IF/MEM stages and the SRAM controller, and also owns a watchdog that unblocks the pipeline if a done pulse never comes.

## Interface
- `TIMEOUT_CYCLES`, default 255: clk cycles in BUSY without the expected done edge before the transaction is aborted.
- `GAP_CYCLES`, default 10: minimum clk cycles `sram_enable` stays low between transactions. Must be ≥ 9, one controller internal-clock period.

- `clk` in 1: single clock; every register is clocked on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_req` in 1; `i_addr` in 32: instruction read request and its address. Reads only.
- `i_rdata` out 32; `i_ack` out 1; `i_err` out 1: instruction read data, done pulse, timeout flag.
- `d_req` in 1; `d_we` in 1; `d_addr` in 32; `d_wdata` in 32: data request, 1 = write, address, write data.
- `d_rdata` out 32; `d_ack` out 1; `d_err` out 1: data read data, done pulse, timeout flag.
- `sram_enable`, `sram_writenable` out 1; `sram_address`, `sram_data_write` out 32: drive the controller's inputs.
- `sram_data_read` in 32; `sram_read_done`, `sram_write_done` in 1: inputs from the controller.
- `grant` out 2: 01 = instruction, 10 = data, 00 = none.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States are IDLE, BUSY and RELEASE.
- **IDLE**
  - Sample `i_req` and `d_req`.
  - If only one is high, grant that port.
  - If both are high, grant the port not recorded in `last_grant`.
  - On grant, register the address, the write flag (0 for instruction) and the write data into the `sram_*` outputs. Set `sram_enable`=1 and `grant`, clear the watchdog, and go to BUSY.
- **BUSY**
  - Register both done inputs; an edge is `done & ~done_q`.
  - Only the edge matching the operation counts: `sram_read_done` for a read, `sram_write_done` for a write. The other done signal is ignored.
  - On the matching edge:
    - For a read, capture `sram_data_read` into the granted port's `rdata`.
    - Pulse that port's `ack`.
    - Drop `sram_enable`, `sram_writenable` and `grant`.
    - Update `last_grant` and go to RELEASE.
  - The watchdog increments each BUSY cycle. When it reaches `TIMEOUT_CYCLES`, take the same exit but pulse `ack` together with `err`; `rdata` is not updated.
- **RELEASE**
  - Load the gap counter with `GAP_CYCLES` and decrement it each cycle.
  - Return to IDLE when the counter reaches 0 and both done inputs are low.
- Handshake rules:
  - A requester holds `req` and its address/data stable until `ack`.
  - It must drop `req` within `GAP_CYCLES` after `ack`; a `req` still high on IDLE re-entry is a new request.
  - `rdata` holds its value until the next successful read ack on that port.
- The `sram_address`/`sram_data_write` registers hold their last values outside BUSY.
- Mid-transaction reset: outputs take their reset values immediately. The controller returns to its idle state under the same reset.

## Timing
- Reset values:
  - All outputs are 0: `i_rdata`, `d_rdata`, `sram_address`, `sram_data_write` = 0; `i_ack`, `d_ack`, `i_err`, `d_err`, `sram_enable`, `sram_writenable`, `busy` = 0; `grant` = 00.
  - State is IDLE, `last_grant` = data (the instruction port wins the first tie), counters are 0.
- A request sampled in IDLE at cycle N gives `sram_enable`, `grant` and `busy` = 1 at N+1.
- A done edge detected at cycle M gives `ack` (and valid `rdata`) at M+1, with `sram_enable` low in that same cycle. `ack` lasts exactly 1 cycle.
- Back-to-back: earliest next grant is `GAP_CYCLES`+1 cycles after `ack`, and never while a done input is still high.
- Watchdog: `ack`+`err` arrive `TIMEOUT_CYCLES`+1 cycles after the grant.
- A done level that is still high on entry to BUSY does not count as an edge; it is registered before any edge is recognised.

## Test plan
- **Reset:** assert `rst`=0 mid-BUSY -> all outputs 0 and `grant`=00 at once; after release with no requests, `busy` stays 0.
- **Single read:** `i_req`, `i_addr`=0x100; controller model returns 0xDEADBEEF and pulses `sram_read_done` for 4 cycles -> exactly one `i_ack`, `i_rdata`=0xDEADBEEF, `sram_enable` low within 1 cycle of the done rise.
- **Write:** `d_req`, `d_we`=1, `d_addr`=0x40, `d_wdata`=0x12345678 -> `sram_writenable`=1, `sram_data_write`=0x12345678, and `d_ack` on the `sram_write_done` edge; `d_rdata` unchanged.
- **Contention:** both requests held continuously -> grants alternate I, D, I, D; each pair of grants is separated by ≥ `GAP_CYCLES` cycles of `sram_enable`=0.
- **Wrong done / timeout:** read granted; model pulses only `sram_write_done`, then nothing -> the pulse is ignored, `i_ack`+`i_err` arrive at grant+256 cycles, `i_rdata` keeps its previous value, and the next request is serviced normally.
